// File: rtl/dash_pkg.sv
// Shared dashboard constants: telemetry frame layout and UART serializer state encoding.
package dash_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         FRAME_LEN = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [7:0] frame_checksum(input logic [7:0] b1, input logic [7:0] b2,
                                                input logic [7:0] b3, input logic [7:0] b4);
    return b1 ^ b2 ^ b3 ^ b4;
  endfunction

endpackage

// File: rtl/telemetry_uart_tx_if.sv
// Telemetry sampling request, dashboard values and UART line status bundled as one port.
interface telemetry_uart_tx_if;

  logic       send_tick;
  logic [8:0] speed_kmh;
  logic [13:0] rpm;
  logic [2:0] gear;
  logic       overload;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic       overrun;

  modport master (
    output send_tick, speed_kmh, rpm, gear, overload,
    input  tx, busy, frame_done, overrun
  );

  modport slave (
    input  send_tick, speed_kmh, rpm, gear, overload,
    output tx, busy, frame_done, overrun
  );

endinterface

// File: rtl/telemetry_uart_tx_byte.sv
// Serializes one byte as UART 8N1; a start accepted at the end of a stop bit chains the next byte with no idle gap.
module uart_byte_tx
  import dash_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);
  assign ready   = (state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end);
  assign tx      = tx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // tx_d is the line level for the next cycle, so every state entry also sets the new bit value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (start) begin
          state_d = ST_START;
          shift_d = data;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (start) begin
            state_d = ST_START;
            shift_d = data;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/telemetry_uart_tx.sv
// Snapshots speed/rpm/gear/overload on a tick and streams a 6-byte checksummed frame out over UART 8N1.
module telemetry_uart_tx
  import dash_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic              clk,
  input  logic              rst_n,
  telemetry_uart_tx_if.slave bus
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  logic       busy_q;
  logic       frame_done_q;
  logic [2:0] byte_idx_q;
  logic [7:0] snap_q [1:FRAME_LEN-1];

  logic       accept, last_byte, next_byte, frame_end;
  logic       byte_start, byte_ready, line;
  logic [2:0] next_idx;
  logic [7:0] byte_data;
  logic [7:0] b1, b2, b3, b4;

  assign b1 = {bus.overload, bus.gear, 3'b000, bus.speed_kmh[8]};
  assign b2 = bus.speed_kmh[7:0];
  assign b3 = {2'b00, bus.rpm[13:8]};
  assign b4 = bus.rpm[7:0];

  assign accept     = bus.send_tick && !busy_q;
  assign last_byte  = (byte_idx_q == LAST_IDX);
  assign next_byte  = busy_q && byte_ready && !last_byte;
  assign frame_end  = busy_q && byte_ready && last_byte;
  assign next_idx   = last_byte ? byte_idx_q : byte_idx_q + 3'd1;
  assign byte_start = accept || next_byte;
  assign byte_data  = accept ? SYNC_BYTE : snap_q[next_idx];

  // The sync byte goes straight to the serializer on the accepting cycle; only B1..B5 need storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      byte_idx_q   <= '0;
      for (int i = 1; i < FRAME_LEN; i++) snap_q[i] <= '0;
    end else begin
      frame_done_q <= frame_end;
      if (accept) begin
        busy_q     <= 1'b1;
        byte_idx_q <= '0;
        snap_q[1]  <= b1;
        snap_q[2]  <= b2;
        snap_q[3]  <= b3;
        snap_q[4]  <= b4;
        snap_q[5]  <= frame_checksum(b1, b2, b3, b4);
      end else if (next_byte) begin
        byte_idx_q <= next_idx;
      end else if (frame_end) begin
        busy_q <= 1'b0;
      end
    end
  end

  uart_byte_tx #(.DIV(DIV)) u_byte_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (byte_start),
    .data  (byte_data),
    .ready (byte_ready),
    .tx    (line)
  );

  assign bus.tx         = line;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overrun    = bus.send_tick && busy_q;

endmodule

// File: tb/tb_telemetry_uart_tx.sv
// Directed frames through telemetry_uart_tx with a UART-decoding scoreboard and frame_done timing checks.
module tb_telemetry_uart_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 125_000;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int HALF     = DIV / 2;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  int vectors    = 0;
  int miscompares = 0;
  int ovr_seen   = 0;
  int ovr_exp    = 0;

  logic [7:0] exp_q [$];
  int         done_q [$];

  int   v_speed [5] = '{123, 511, 0, 256, 200};
  int   v_rpm   [5] = '{4500, 16383, 0, 256, 1000};
  int   v_gear  [5] = '{3, 7, 0, 5, 2};
  int   v_ovl   [5] = '{0, 1, 0, 0, 1};
  logic [7:0] v_bytes [5][6] = '{
    '{8'hA5, 8'h30, 8'h7B, 8'h11, 8'h94, 8'hCE},
    '{8'hA5, 8'hF1, 8'hFF, 8'h3F, 8'hFF, 8'hCE},
    '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'hA5, 8'h51, 8'h00, 8'h01, 8'h00, 8'h50},
    '{8'hA5, 8'hA0, 8'hC8, 8'h03, 8'hE8, 8'h83}
  };

  telemetry_uart_tx_if bus ();

  telemetry_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drives a tick in the current cycle (caller sits just after a posedge) and queues the expected frame.
  task automatic applyStimulus(input int v);
    int t;
    bus.speed_kmh = 9'(v_speed[v]);
    bus.rpm       = 14'(v_rpm[v]);
    bus.gear      = 3'(v_gear[v]);
    bus.overload  = 1'(v_ovl[v]);
    bus.send_tick = 1'b1;
    t = cyc;
    for (int i = 0; i < 6; i++) exp_q.push_back(v_bytes[v][i]);
    done_q.push_back(t + 60 * DIV + 1);
    #1;
    checkOutput("tick_no_overrun", 32'(bus.overrun), 32'd0);
    @(posedge clk); #1;
    bus.send_tick = 1'b0;
    checkOutput("start_bit_latency", 32'(bus.tx), 32'd0);
    checkOutput("busy_rise", 32'(bus.busy), 32'd1);
  endtask

  task automatic waitFrame(input string name);
    for (int i = 0; i < 80 * DIV; i++) begin
      @(posedge clk); #1;
      if (done_q.size() == 0 && exp_q.size() == 0) break;
    end
    checkOutput({name, "_pending"}, 32'(done_q.size() + exp_q.size()), 32'd0);
    checkOutput({name, "_busy_fall"}, 32'(bus.busy), 32'd0);
  endtask

  // UART decoder: samples mid-bit on the negedge and scores each byte against the queue.
  logic       dec_active = 1'b0;
  int         dec_cnt    = 0;
  int         dec_idx;
  logic [7:0] dec_byte;
  logic [7:0] dec_exp;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      dec_active = 1'b0;
    end else if (!dec_active) begin
      if (bus.tx === 1'b0) begin
        dec_active = 1'b1;
        dec_cnt    = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt == HALF) begin
        checkOutput("start_bit_mid", 32'(bus.tx), 32'd0);
      end else if (dec_cnt > HALF && (dec_cnt - HALF) % DIV == 0) begin
        dec_idx = (dec_cnt - HALF) / DIV;
        if (dec_idx <= 8) begin
          dec_byte[dec_idx-1] = bus.tx;
        end else begin
          checkOutput("stop_bit", 32'(bus.tx), 32'd1);
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_byte: got 0x%0h, expected none (cycle %0d)", dec_byte, cyc);
          end else begin
            dec_exp = exp_q.pop_front();
            checkOutput("frame_byte", 32'(dec_byte), 32'(dec_exp));
          end
          dec_active = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.frame_done === 1'b1) begin
      if (done_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_frame_done: got pulse at cycle %0d, expected none", cyc);
      end else begin
        checkOutput("frame_done_cycle", 32'(cyc), 32'(done_q.pop_front()));
      end
    end
    if (bus.overrun === 1'b1) ovr_seen++;
  end

  initial begin
    #(200 * 60 * DIV * 10);
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.send_tick = 1'b0;
    bus.speed_kmh = '0;
    bus.rpm       = '0;
    bus.gear      = '0;
    bus.overload  = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_tx", 32'(bus.tx), 32'd1);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_frame_done", 32'(bus.frame_done), 32'd0);
    checkOutput("reset_overrun", 32'(bus.overrun), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] nominal frame with speed change during byte 1");
    applyStimulus(0);
    repeat (11 * DIV) @(posedge clk);
    #1 bus.speed_kmh = 9'd0;
    waitFrame("nominal");

    $display("[TB] max values with tick during byte 2");
    applyStimulus(1);
    repeat (21 * DIV) @(posedge clk);
    #1;
    bus.send_tick = 1'b1;
    ovr_exp++;
    #1 checkOutput("overrun_pulse", 32'(bus.overrun), 32'd1);
    @(posedge clk); #1;
    bus.send_tick = 1'b0;
    checkOutput("busy_held", 32'(bus.busy), 32'd1);
    waitFrame("max");
    repeat (15 * DIV) @(posedge clk);
    #1 checkOutput("no_second_frame", 32'(bus.busy), 32'd0);

    $display("[TB] back-to-back frames");
    applyStimulus(2);
    repeat (60 * DIV) @(posedge clk);
    #1;
    checkOutput("b2b_frame_done", 32'(bus.frame_done), 32'd1);
    checkOutput("b2b_busy_low", 32'(bus.busy), 32'd0);
    applyStimulus(3);
    waitFrame("b2b");

    $display("[TB] reset during byte 3 data bits");
    applyStimulus(4);
    repeat (32 * DIV) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_tx", 32'(bus.tx), 32'd1);
    checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
    checkOutput("midreset_bytes_left", 32'(exp_q.size()), 32'd3);
    exp_q.delete();
    done_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_reset_idle_tx", 32'(bus.tx), 32'd1);
    applyStimulus(4);
    waitFrame("after_reset");

    repeat (20) @(posedge clk);
    #1;
    checkOutput("overrun_count", 32'(ovr_seen), 32'(ovr_exp));
    checkOutput("scoreboard_empty", 32'(exp_q.size() + done_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
